// File: rtl/demux1x7_buffered.sv
// Routes one word stream to one of NUM_OUT channels, each with a one-deep
// valid/ready output register. Out-of-range selects are dropped and counted.
//
// state | meaning
// EMPTY | channel register holds no word, out_valid[k]=0
// FULL  | channel register holds a word for consumer k, out_valid[k]=1
module demux1x7_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 3,
  parameter int NUM_OUT    = 7
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [SEL_WIDTH-1:0]          in_select,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic                          sel_error,
  output logic [7:0]                    drop_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_e;

  ch_state_e                            state_q [NUM_OUT];
  ch_state_e                            state_d [NUM_OUT];
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0]   data_q;
  logic [NUM_OUT-1:0][DATA_WIDTH-1:0]   data_d;
  logic                                 sel_error_q;
  logic                                 sel_error_d;
  logic [7:0]                           drop_q;
  logic [7:0]                           drop_d;

  logic [NUM_OUT-1:0] sel_onehot;
  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] load;
  logic               sel_hit;
  logic               accept;
  logic               drop_word;

  always_comb begin
    sel_onehot = '0;
    full       = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      sel_onehot[k] = (in_select == SEL_WIDTH'(k));
      full[k]       = (state_q[k] == FULL);
    end
  end

  assign sel_hit   = |sel_onehot;
  // A full channel can still take a word when its consumer drains it the same edge.
  assign in_ready  = !flush && (!sel_hit || |(sel_onehot & (~full | out_ready)));
  assign accept    = in_valid && in_ready;
  assign load      = {NUM_OUT{accept}} & sel_onehot;
  assign drop_word = accept && !sel_hit;

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      state_d[k] = state_q[k];
      data_d[k]  = data_q[k];
      if (flush) begin
        state_d[k] = EMPTY;
      end else if (load[k]) begin
        state_d[k] = FULL;
        data_d[k]  = in_data;
      end else if (out_ready[k]) begin
        state_d[k] = EMPTY;
      end
    end
    sel_error_d = drop_word;
    drop_d      = (drop_word && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        state_q[k] <= EMPTY;
      end
      data_q      <= '0;
      sel_error_q <= 1'b0;
      drop_q      <= 8'h00;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        state_q[k] <= state_d[k];
      end
      data_q      <= data_d;
      sel_error_q <= sel_error_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid  = full;
  assign out_data   = data_q;
  assign sel_error  = sel_error_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_demux1x7_buffered.sv
// Self-checking bench for demux1x7_buffered: directed vector table, hand
// sequences for stall/flush/saturation, and randomized traffic against a model.
module tb_demux1x7_buffered;

  localparam int NO = 7;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_select = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [223:0] out_data;
  logic [6:0]   out_valid;
  logic [6:0]   out_ready = '0;
  logic         sel_error;
  logic [7:0]   drop_count;

  demux1x7_buffered dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel_error  (sel_error),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_mis = 0;
  bit          m_valid [NO];
  logic [31:0] m_data  [NO];
  int          m_drop;
  bit          m_serr;
  logic        got_rdy;

  typedef struct {
    bit          fl;
    bit          vld;
    logic [2:0]  sel;
    logic [31:0] data;
    logic [6:0]  ordy;
    bit          e_rdy;
    logic [6:0]  e_valid;
    bit          e_serr;
    logic [7:0]  e_drop;
    int          e_ch;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] m_vbits();
    logic [6:0] r;
    for (int k = 0; k < NO; k++) r[k] = m_valid[k];
    return r;
  endfunction

  function automatic logic [223:0] m_dbits();
    logic [223:0] r;
    for (int k = 0; k < NO; k++) r[k*32 +: 32] = m_data[k];
    return r;
  endfunction

  function automatic bit m_rdy();
    if (flush) return 1'b0;
    if (int'(in_select) >= NO) return 1'b1;
    return !m_valid[in_select] || out_ready[in_select];
  endfunction

  function automatic logic [31:0] ch_data(input int k);
    return out_data[k*32 +: 32];
  endfunction

  // Inputs are set just after an edge; this samples in_ready, advances the model
  // and the DUT one edge, then compares every output.
  task automatic tick();
    bit exp_rdy;
    bit acc;
    #2;
    got_rdy = in_ready;
    exp_rdy = m_rdy();
    chk("in_ready", 224'(in_ready), 224'(exp_rdy));
    acc    = in_valid && exp_rdy;
    m_serr = acc && (int'(in_select) >= NO);
    if (m_serr && m_drop < 255) m_drop++;
    for (int k = 0; k < NO; k++) begin
      if (flush) m_valid[k] = 1'b0;
      else if (acc && int'(in_select) == k) begin
        m_valid[k] = 1'b1;
        m_data[k]  = in_data;
      end else if (out_ready[k]) m_valid[k] = 1'b0;
    end
    @(posedge clock);
    #1;
    chk("out_valid", 224'(out_valid), 224'(m_vbits()));
    chk("out_data", out_data, m_dbits());
    chk("sel_error", 224'(sel_error), 224'(m_serr));
    chk("drop_count", 224'(drop_count), 224'(m_drop));
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_select = 3'd3;
    in_data   = 32'h1234_5678;
    flush     = 1'b0;
    out_ready = '0;
    for (int k = 0; k < NO; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    m_drop = 0;
    m_serr = 1'b0;
    @(posedge clock);
    #3;
    chk("rst_out_valid", 224'(out_valid), 224'(0));
    chk("rst_drop_count", 224'(drop_count), 224'(0));
    chk("rst_sel_error", 224'(sel_error), 224'(0));
    chk("rst_out_data", out_data, 224'(0));
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    chk("rst_in_ready", 224'(in_ready), 224'(1));
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pulses;

    tbl[0] = '{1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 7'b0000000, 1'b1, 7'b0001000, 1'b0, 8'd0, 3, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 1'b1, 3'd2, 32'h11111111, 7'b0000000, 1'b1, 7'b0001100, 1'b0, 8'd0, 2, 32'h11111111};
    tbl[2] = '{1'b0, 1'b1, 3'd2, 32'h22222222, 7'b0000000, 1'b0, 7'b0001100, 1'b0, 8'd0, 2, 32'h11111111};
    tbl[3] = '{1'b0, 1'b1, 3'd2, 32'h22222222, 7'b0000100, 1'b1, 7'b0001100, 1'b0, 8'd0, 2, 32'h22222222};
    tbl[4] = '{1'b0, 1'b1, 3'd7, 32'h77777777, 7'b0000000, 1'b1, 7'b0001100, 1'b1, 8'd1, 3, 32'hDEADBEEF};
    tbl[5] = '{1'b0, 1'b0, 3'd0, 32'h00000000, 7'b0001000, 1'b1, 7'b0000100, 1'b0, 8'd1, 3, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 1'b1, 3'd1, 32'h55555555, 7'b0000000, 1'b0, 7'b0000000, 1'b0, 8'd1, 2, 32'h22222222};
    tbl[7] = '{1'b0, 1'b1, 3'd0, 32'hAAAAAAAA, 7'b0000000, 1'b1, 7'b0000001, 1'b0, 8'd1, 0, 32'hAAAAAAAA};

    do_reset();

    for (int i = 0; i < 8; i++) begin
      flush     = tbl[i].fl;
      in_valid  = tbl[i].vld;
      in_select = tbl[i].sel;
      in_data   = tbl[i].data;
      out_ready = tbl[i].ordy;
      tick();
      chk($sformatf("tbl%0d_in_ready", i), 224'(got_rdy), 224'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_out_valid", i), 224'(out_valid), 224'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_sel_error", i), 224'(sel_error), 224'(tbl[i].e_serr));
      chk($sformatf("tbl%0d_drop", i), 224'(drop_count), 224'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_data", i), 224'(ch_data(tbl[i].e_ch)), 224'(tbl[i].e_data));
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = '0;

    // Saturating drop counter: 300 bad-select words.
    do_reset();
    pulses = 0;
    in_valid  = 1'b1;
    in_select = 3'd7;
    for (int i = 0; i < 300; i++) begin
      in_data = $urandom;
      tick();
      if (sel_error) pulses++;
    end
    in_valid = 1'b0;
    chk("bad_sel_pulses", 224'(pulses), 224'(300));
    chk("bad_sel_drop_sat", 224'(drop_count), 224'(255));
    chk("bad_sel_no_valid", 224'(out_valid), 224'(0));

    // Flush colliding with a load request.
    do_reset();
    in_valid = 1'b1;
    in_select = 3'd0; in_data = 32'hC0C0C0C0; tick();
    in_select = 3'd5; in_data = 32'hC5C5C5C5; tick();
    chk("flush_pre_valid", 224'(out_valid), 224'(7'b0100001));
    flush = 1'b1; in_select = 3'd1; in_data = 32'hC1C1C1C1; tick();
    chk("flush_in_ready", 224'(got_rdy), 224'(0));
    chk("flush_out_valid", 224'(out_valid), 224'(0));
    chk("flush_ch1_data", 224'(ch_data(1)), 224'(0));
    chk("flush_ch5_kept", 224'(ch_data(5)), 224'(32'hC5C5C5C5));
    flush = 1'b0;
    in_valid = 1'b0;

    // Independence: channel 4 stalled, channel 0 stalls on its second word.
    do_reset();
    in_valid = 1'b1;
    in_select = 3'd4; in_data = 32'h44444444; tick();
    in_select = 3'd0; in_data = 32'hA0A0A0A0; tick();
    chk("ind_w0_rdy", 224'(got_rdy), 224'(1));
    in_select = 3'd1; in_data = 32'hA1A1A1A1; tick();
    chk("ind_w1_rdy", 224'(got_rdy), 224'(1));
    in_select = 3'd6; in_data = 32'hA6A6A6A6; tick();
    chk("ind_w6_rdy", 224'(got_rdy), 224'(1));
    in_select = 3'd0; in_data = 32'hB0B0B0B0; tick();
    chk("ind_w0b_stall", 224'(got_rdy), 224'(0));
    tick();
    chk("ind_w0b_stall2", 224'(got_rdy), 224'(0));
    chk("ind_ch0_hold", 224'(ch_data(0)), 224'(32'hA0A0A0A0));
    out_ready = 7'b0000001; tick();
    chk("ind_w0b_rdy", 224'(got_rdy), 224'(1));
    chk("ind_ch0_new", 224'(ch_data(0)), 224'(32'hB0B0B0B0));
    chk("ind_valid", 224'(out_valid), 224'(7'b1010011));
    in_valid = 1'b0;
    out_ready = '0;

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_select = 3'($urandom_range(0, 7));
      in_data   = $urandom;
      out_ready = 7'($urandom);
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
